id2ex_stage: RTL

- ID/EX pipeline stage register, directly downstream of the ID-stage control decoder.
- Captures the decoded control bundles (ALU, MEM, WB), the immediate, the register addresses and the register-file read data into the EX stage.
- Contains load-use hazard detection: drives a stall to the PC and IF/ID register and inserts a one-cycle bubble into EX.

---
 rtl/id2ex_stage_pkg.sv | 38 +++
 rtl/id_hazard_detect.sv | 32 +++
 rtl/id2ex_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/id2ex_stage_pkg.sv
// ============================================================================
// Module      : id2ex_stage_pkg
// Description : Shared field widths, bit indices and opcodes for the ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package id2ex_stage_pkg;

    localparam int EXALU_W = 14;
    localparam int EXMEM_W = 2;
    localparam int WB_W    = 5;

    localparam int EXMEM_MEMWRITE = 0;
    localparam int EXMEM_MEMREAD  = 1;
    localparam int WB_REGWRITE    = 0;
    localparam int WB_MEMTORES    = 1;

    localparam logic [0:5] OP_RTYPE = 6'b101010;
    localparam logic [0:5] OP_LD    = 6'b100000;
    localparam logic [0:5] OP_SW    = 6'b100001;
    localparam logic [0:5] OP_BEQ   = 6'b100010;
    localparam logic [0:5] OP_BNE   = 6'b100011;
    localparam logic [0:5] OP_NOP   = 6'b111100;

    typedef struct packed {
        logic [0:EXALU_W-1] exalu;
        logic [0:EXMEM_W-1] exmem;
        logic [0:WB_W-1]    wb;
    } ctrl_t;

    function automatic logic is_load(input logic [0:EXMEM_W-1] exmem);
        return exmem[EXMEM_MEMREAD];
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_hazard_detect.sv
// ============================================================================
// Module      : id_hazard_detect
// Description : Combinational load-use compare between the ID sources and EX rd.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_hazard_detect #(
    parameter int RADDR_W = 5
) (
    input  logic               id_valid,
    input  logic               id_uses_ra,
    input  logic               id_uses_rb,
    input  logic [0:RADDR_W-1] id_ra_addr,
    input  logic [0:RADDR_W-1] id_rb_addr,
    input  logic               ex_valid,
    input  logic               ex_is_load,
    input  logic [0:RADDR_W-1] ex_rd_addr,
    output logic               hz_stall
);

    logic ra_hit;
    logic rb_hit;

    // Register 0 is not hardwired, so an address-0 match is a real hazard.
    assign ra_hit   = id_uses_ra & (id_ra_addr == ex_rd_addr);
    assign rb_hit   = id_uses_rb & (id_rb_addr == ex_rd_addr);
    assign hz_stall = id_valid & ex_valid & ex_is_load & (ra_hit | rb_hit);

endmodule

`default_nettype wire

// File: rtl/id2ex_stage.sv
// ============================================================================
// Module      : id2ex_stage
// Description : ID/EX pipeline register with load-use stall and bubble insert.
//               Optional stall-bubble counter enabled by ID2EX_BUBBLE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id2ex_stage
    import id2ex_stage_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int RADDR_W = 5,
    parameter int IMM_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [0:EXALU_W-1] id_exalu_ctrl,
    input  logic [0:EXMEM_W-1] id_exmem_ctrl,
    input  logic [0:WB_W-1]    id_wb_ctrl,
    input  logic [0:IMM_W-1]   id_imme,
    input  logic [0:RADDR_W-1] id_rd_addr,
    input  logic [0:RADDR_W-1] id_ra_addr,
    input  logic [0:RADDR_W-1] id_rb_addr,
    input  logic               id_uses_ra,
    input  logic               id_uses_rb,
    input  logic [0:DATA_W-1]  id_ra_data,
    input  logic [0:DATA_W-1]  id_rb_data,
    input  logic               id2ex_flush,
    input  logic               pipe_hold,
    output logic               ex_valid,
    output logic [0:EXALU_W-1] ex_exalu_ctrl,
    output logic [0:EXMEM_W-1] ex_exmem_ctrl,
    output logic [0:WB_W-1]    ex_wb_ctrl,
    output logic [0:IMM_W-1]   ex_imme,
    output logic [0:RADDR_W-1] ex_rd_addr,
    output logic [0:RADDR_W-1] ex_ra_addr,
    output logic [0:RADDR_W-1] ex_rb_addr,
    output logic [0:DATA_W-1]  ex_ra_data,
    output logic [0:DATA_W-1]  ex_rb_data,
    output logic               hz_stall
`ifdef ID2EX_BUBBLE_CNT_EN
    ,
    output logic [0:31]        bubble_cnt
`endif
);

    logic               valid_d,   valid_q;
    ctrl_t              ctrl_d,    ctrl_q;
    logic [0:IMM_W-1]   imme_d,    imme_q;
    logic [0:RADDR_W-1] rd_addr_d, rd_addr_q;
    logic [0:RADDR_W-1] ra_addr_d, ra_addr_q;
    logic [0:RADDR_W-1] rb_addr_d, rb_addr_q;
    logic [0:DATA_W-1]  ra_data_d, ra_data_q;
    logic [0:DATA_W-1]  rb_data_d, rb_data_q;

    ctrl_t ctrl_in;
    logic  load_bubble;

    assign ctrl_in = {id_exalu_ctrl, id_exmem_ctrl, id_wb_ctrl};

    id_hazard_detect #(
        .RADDR_W (RADDR_W)
    ) u_hazard (
        .id_valid   (id_valid),
        .id_uses_ra (id_uses_ra),
        .id_uses_rb (id_uses_rb),
        .id_ra_addr (id_ra_addr),
        .id_rb_addr (id_rb_addr),
        .ex_valid   (valid_q),
        .ex_is_load (is_load(ctrl_q.exmem)),
        .ex_rd_addr (rd_addr_q),
        .hz_stall   (hz_stall)
    );

    // Flush beats hold; a load-use stall only bubbles once the hold is released.
    assign load_bubble = id2ex_flush | (~pipe_hold & hz_stall);

    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        imme_d    = imme_q;
        rd_addr_d = rd_addr_q;
        ra_addr_d = ra_addr_q;
        rb_addr_d = rb_addr_q;
        ra_data_d = ra_data_q;
        rb_data_d = rb_data_q;
        if (load_bubble) begin
            valid_d   = 1'b0;
            ctrl_d    = '0;
            imme_d    = '0;
            rd_addr_d = '0;
            ra_addr_d = '0;
            rb_addr_d = '0;
            ra_data_d = '0;
            rb_data_d = '0;
        end else if (!pipe_hold) begin
            valid_d   = id_valid;
            ctrl_d    = ctrl_in;
            imme_d    = id_imme;
            rd_addr_d = id_rd_addr;
            ra_addr_d = id_ra_addr;
            rb_addr_d = id_rb_addr;
            ra_data_d = id_ra_data;
            rb_data_d = id_rb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            imme_q    <= '0;
            rd_addr_q <= '0;
            ra_addr_q <= '0;
            rb_addr_q <= '0;
            ra_data_q <= '0;
            rb_data_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            imme_q    <= imme_d;
            rd_addr_q <= rd_addr_d;
            ra_addr_q <= ra_addr_d;
            rb_addr_q <= rb_addr_d;
            ra_data_q <= ra_data_d;
            rb_data_q <= rb_data_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_exalu_ctrl = ctrl_q.exalu;
    assign ex_exmem_ctrl = ctrl_q.exmem;
    assign ex_wb_ctrl    = ctrl_q.wb;
    assign ex_imme       = imme_q;
    assign ex_rd_addr    = rd_addr_q;
    assign ex_ra_addr    = ra_addr_q;
    assign ex_rb_addr    = rb_addr_q;
    assign ex_ra_data    = ra_data_q;
    assign ex_rb_data    = rb_data_q;

`ifdef ID2EX_BUBBLE_CNT_EN
    logic [0:31] bubble_cnt_d, bubble_cnt_q;
    logic        stall_bubble;

    // Only bubbles caused by the load-use stall are counted, never flushes.
    assign stall_bubble = ~id2ex_flush & ~pipe_hold & hz_stall;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (stall_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire
